// File: rtl/matrix_read_arbiter.sv
// matrix_read_arbiter: round-robin sharing of the single matrix_storage read port.
// Optional WAIT-state watchdog is enabled by defining MATRIX_RD_TIMEOUT_EN.
module matrix_read_arbiter #(
    parameter int NREQ        = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [4*NREQ-1:0]    req_idx_flat,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_done,
    output logic                 rsp_valid,
    output logic [3:0]           rsp_m,
    output logic [3:0]           rsp_n,
    output logic [3:0]           rsp_id,
    output logic [199:0]         rsp_data,
    output logic [3:0]           st_read_idx,
    output logic                 st_read_en,
    input  logic                 st_read_done,
    input  logic                 st_read_valid,
    input  logic [3:0]           st_out_m,
    input  logic [3:0]           st_out_n,
    input  logic [3:0]           st_out_id,
    input  logic [199:0]         st_out_data,
    output logic                 busy,
    output logic                 timeout_err
);

    if (NREQ < 2 || NREQ > 4 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_cfg
        $error("matrix_read_arbiter: NREQ must be 2..4 and TIMEOUT_CYC 1..255");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state;
    logic [1:0] rr_ptr;
    logic [1:0] gsel;
    logic [1:0] pick;
    logic [1:0] cand;
    logic       any_req;

`ifdef MATRIX_RD_TIMEOUT_EN
    logic [7:0] wait_cnt;
`endif

    // First set request bit at or above rr_ptr, wrapping modulo NREQ.
    always_comb begin
        pick    = '0;
        cand    = '0;
        any_req = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = 2'((32'(rr_ptr) + i) % NREQ);
            if (!any_req && req[cand]) begin
                pick    = cand;
                any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            gsel        <= '0;
            gnt         <= '0;
            rsp_done    <= '0;
            rsp_valid   <= 1'b0;
            rsp_m       <= '0;
            rsp_n       <= '0;
            rsp_id      <= '0;
            rsp_data    <= '0;
            st_read_idx <= '0;
            st_read_en  <= 1'b0;
            busy        <= 1'b0;
`ifdef MATRIX_RD_TIMEOUT_EN
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gsel        <= pick;
                        gnt         <= NREQ'(1) << pick;
                        st_read_idx <= req_idx_flat[4*pick +: 4];
                        st_read_en  <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A completion seen during this cycle is deliberately ignored.
                    st_read_en <= 1'b0;
`ifdef MATRIX_RD_TIMEOUT_EN
                    wait_cnt   <= '0;
`endif
                    state      <= WAIT;
                end
                WAIT: begin
                    if (st_read_done) begin
                        rsp_valid <= st_read_valid;
                        rsp_m     <= st_out_m;
                        rsp_n     <= st_out_n;
                        rsp_id    <= st_out_id;
                        rsp_data  <= st_out_data;
                        rsp_done  <= gnt;
                        state     <= RESP;
                    end
`ifdef MATRIX_RD_TIMEOUT_EN
                    else if (32'(wait_cnt) == 32'(TIMEOUT_CYC - 1)) begin
                        rsp_valid   <= 1'b0;
                        rsp_done    <= gnt;
                        timeout_err <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                RESP: begin
                    rsp_done <= '0;
                    gnt      <= '0;
                    busy     <= 1'b0;
                    rr_ptr   <= (32'(gsel) == 32'(NREQ - 1)) ? '0 : gsel + 2'd1;
`ifdef MATRIX_RD_TIMEOUT_EN
                    timeout_err <= 1'b0;
`endif
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef MATRIX_RD_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/matrix_read_arbiter.md
Name: matrix_read_arbiter

Overview:
- Shares the single matrix_storage read port (read_idx/read_en → read_done/read_valid/read_out_*) among NREQ requesters: operand loader, display scanner, UART dump engine.
- Round-robin arbitration with one storage read in flight at a time.
- Returns the fetched dimensions, ID and data on a shared response bus, with a per-requester done pulse.
- Sits between matrix_storage and its clients inside the core top level.

Parameters:
- NREQ, 3, number of requesters (2..4); index 0 is highest priority at reset.
- TIMEOUT_CYC, 64, WAIT-state cycle limit; used only with MATRIX_RD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req  in  NREQ  per-requester read request level; held until that requester's rsp_done
- req_idx_flat  in  4*NREQ  storage slot index, requester k at bits [4k+3:4k]
- gnt  out  NREQ  one-hot grant, high from ISSUE through RESP inclusive
- rsp_done  out  NREQ  one-cycle pulse to the granted requester
- rsp_valid  out  1  registered read_valid of the completed access (0 on timeout)
- rsp_m  out  4  registered row count
- rsp_n  out  4  registered column count
- rsp_id  out  4  registered matrix ID
- rsp_data  out  200  registered 5x5x8 matrix data
- st_read_idx  out  4  index to storage
- st_read_en  out  1  one-cycle read strobe to storage
- st_read_done  in  1  storage completion pulse
- st_read_valid  in  1  storage slot-valid flag
- st_out_m  in  4  storage row count
- st_out_n  in  4  storage column count
- st_out_id  in  4  storage matrix ID
- st_out_data  in  200  storage matrix data
- busy  out  1  high whenever state != IDLE
- timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, all outputs 0 (gnt, rsp_done, rsp_*, st_read_idx, st_read_en, busy, timeout_err).
- Reset asserted mid-transaction: abandons the access immediately; no rsp_done is emitted.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is set, select the first set bit searching from rr_ptr upward, wrapping modulo NREQ.
  - Register gnt one-hot and st_read_idx = that requester's index; go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE: st_read_en=1 for exactly this cycle; go to WAIT.
- WAIT:
  - On st_read_done, capture st_read_valid/st_out_m/st_out_n/st_out_id/st_out_data into rsp_*; go to RESP.
  - st_read_done arriving in the same cycle as ISSUE is ignored; it is accepted only in WAIT.
- RESP:
  - rsp_done[g]=1 for one cycle.
  - rr_ptr <= (g+1) mod NREQ.
  - Clear gnt at exit; return to IDLE.
- Latency: req seen in IDLE at cycle t → gnt and st_read_idx valid at t+1 → st_read_en at t+1 → rsp_done at (read_done cycle)+1.
- Back-to-back: minimum 4 cycles per access when storage answers one cycle after st_read_en.
- Simultaneous requests: served in rotation starting at rr_ptr; no requester waits more than NREQ-1 transactions.
- req dropped after grant: the transaction still completes and rsp_done still pulses; the requester ignores it.
- req_idx changed after grant: ignored; the index is latched in IDLE.
- req re-asserted during RESP: evaluated in the following IDLE cycle.
- rsp_* hold their last captured values until the next capture.
- Index range checking belongs to storage; rsp_valid=0 reports an empty or invalid slot, and the arbiter passes it through unchanged.

Optional Feature:
- Macro: MATRIX_RD_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC without st_read_done, go to RESP with rsp_valid=0, rsp_m/n/id/data unchanged, and pulse timeout_err in the same cycle as rsp_done.
  - A st_read_done arriving later in IDLE is discarded.
- Undefined: no counter exists; WAIT persists until st_read_done; timeout_err is tied to 0.

Test Plan:
- Single requester: req=3'b001, idx0=4'd2; storage returns m=3, n=4, id=2, valid=1 one cycle after st_read_en → st_read_idx=2, one st_read_en pulse, rsp_done=3'b001 pulse, rsp_m=3, rsp_n=4, rsp_id=2, rsp_valid=1.
- Contention: req=3'b111 held continuously, idx={5,4,3} → grants in order 001,010,100,001; st_read_idx sequence 3,4,5,3; each rsp_done goes to the matching requester.
- Invalid slot: idx=4'd9, storage returns valid=0 → rsp_valid=0, rsp_done still pulses, state back to IDLE.
- Request withdrawn: req[1] high for one cycle only, then 0 → access to its idx completes; rsp_done[1] pulses once; rr_ptr becomes 2.
- Reset mid-WAIT: assert rst two cycles after st_read_en → gnt=0, busy=0, no rsp_done; a subsequent req=3'b100 is granted first.
- Timeout (MATRIX_RD_TIMEOUT_EN defined, TIMEOUT_CYC=8): storage never answers → rsp_done and timeout_err pulse together 8 cycles into WAIT, rsp_valid=0; without the macro, busy stays 1 indefinitely.
